// File: rtl/gry_ptr_sync_if.sv
// Pointer-comparator bundle for one side of an async FIFO.
// Signalling: there is no valid/ready pair here. loc_en is a one-cycle
// qualifier sampled on every rising clk edge; when high, the local gray counter
// advances to loc_gry_cnt_nxt on that same edge. All status outputs are
// registered and valid every cycle outside reset. rmt_gry_ptr is asynchronous
// to clk and is only sampled through the synchronizer.
interface gry_ptr_sync_if #(
  parameter int PTR_W = 5
);
  logic [PTR_W-1:0] loc_gry_cnt;
  logic [PTR_W-1:0] loc_gry_cnt_nxt;
  logic             loc_en;
  logic [PTR_W-1:0] rmt_gry_ptr;
  logic [PTR_W-1:0] thr;
  logic [PTR_W-1:0] rmt_gry_sync;
  logic             ptr_flag;
  logic             prog_flag;
  logic [PTR_W-1:0] occ;
  logic             ptr_err;

  // Counter/environment side: drives pointers and threshold, observes status.
  modport master (
    output loc_gry_cnt, loc_gry_cnt_nxt, loc_en, rmt_gry_ptr, thr,
    input  rmt_gry_sync, ptr_flag, prog_flag, occ, ptr_err
  );

  // Comparator side.
  modport slave (
    input  loc_gry_cnt, loc_gry_cnt_nxt, loc_en, rmt_gry_ptr, thr,
    output rmt_gry_sync, ptr_flag, prog_flag, occ, ptr_err
  );
endinterface

// File: rtl/gry_ptr_sync.sv
// Async FIFO pointer comparator. Synchronizes the remote gray pointer and
// derives registered full/empty, occupancy, threshold flag and a sticky
// overflow/underflow error for the local clock domain.
// LOCAL_IS_WR=1: write side (flag = full, prog = almost-full).
// LOCAL_IS_WR=0: read side (flag = empty, prog = almost-empty).
// The local counter's next value is used so that local updates show up on the
// same edge the counter moves; remote updates arrive SYNC_STAGES+1 edges late,
// which keeps both flags conservative.
module gry_ptr_sync #(
  parameter int PTR_W       = 5,
  parameter int SYNC_STAGES = 2,
  parameter bit LOCAL_IS_WR = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  gry_ptr_sync_if.slave  bus
);

  // Flags come out of reset as "full=0" on the write side and "empty=1" on the
  // read side, matching counters that both reset to 0.
  localparam logic RST_FLAG = ~LOCAL_IS_WR;

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] rmt_sync;
  logic [PTR_W-1:0] rmt_bin;
  logic [PTR_W-1:0] loc_bin_nxt;
  logic [PTR_W-1:0] full_ref;
  logic             full_c;
  logic             empty_c;
  logic             flag_c;
  logic             prog_c;
  logic [PTR_W-1:0] occ_c;
  logic             flag_q;
  logic             prog_q;
  logic [PTR_W-1:0] occ_q;
  logic             err_q;

  function automatic logic [PTR_W-1:0] gry2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain on the remote pointer; nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.rmt_gry_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rmt_sync    = sync_q[SYNC_STAGES-1];
  assign rmt_bin     = gry2bin(rmt_sync);
  assign loc_bin_nxt = gry2bin(bus.loc_gry_cnt_nxt);

  // Full pattern: remote pointer one whole lap behind, which in gray code means
  // the top two bits inverted (just the MSB pair when the pointer is 2 bits).
  generate
    if (PTR_W == 2) begin : g_full_w2
      assign full_ref = ~rmt_sync;
    end else begin : g_full_wn
      assign full_ref = {~rmt_sync[PTR_W-1:PTR_W-2], rmt_sync[PTR_W-3:0]};
    end
  endgenerate

  // Next-state status; modular subtraction keeps occupancy right across wraps.
  always_comb begin
    full_c  = (bus.loc_gry_cnt_nxt == full_ref);
    empty_c = (bus.loc_gry_cnt_nxt == rmt_sync);
    flag_c  = LOCAL_IS_WR ? full_c : empty_c;
    occ_c   = LOCAL_IS_WR ? (loc_bin_nxt - rmt_bin) : (rmt_bin - loc_bin_nxt);
    prog_c  = LOCAL_IS_WR ? (occ_c >= bus.thr) : (occ_c <= bus.thr);
  end

  // Status registers, updated every edge; error is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= RST_FLAG;
      prog_q <= RST_FLAG;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_c;
      prog_q <= prog_c;
      occ_q  <= occ_c;
      if (bus.loc_en && flag_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.rmt_gry_sync = rmt_sync;
  assign bus.ptr_flag     = flag_q;
  assign bus.prog_flag    = prog_q;
  assign bus.occ          = occ_q;
  assign bus.ptr_err      = err_q;

endmodule

// File: tb/tb_gry_ptr_sync.sv
// Bench for gry_ptr_sync: a write-side and a read-side instance share one clock
// and model a FIFO. Write count w and read count r are plain integers; each side
// sees the other's count through a history queue delayed by the sync depth.
module tb_gry_ptr_sync;
  localparam int W     = 5;
  localparam int S     = 2;
  localparam int DEPTH = 1 << (W - 1);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  gry_ptr_sync_if #(.PTR_W(W)) wr_if ();
  gry_ptr_sync_if #(.PTR_W(W)) rd_if ();

  gry_ptr_sync #(.PTR_W(W), .SYNC_STAGES(S), .LOCAL_IS_WR(1'b1)) u_wr (
    .clk(clk), .rst_n(rst_n), .bus(wr_if.slave));
  gry_ptr_sync #(.PTR_W(W), .SYNC_STAGES(S), .LOCAL_IS_WR(1'b0)) u_rd (
    .clk(clk), .rst_n(rst_n), .bus(rd_if.slave));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int w, r;
  int wr_hist[$];
  int rd_hist[$];
  logic [W-1:0] thr_wr, thr_rd;
  logic [W-1:0] m_occ_wr, m_occ_rd, m_sync_wr, m_sync_rd;
  logic m_full, m_prog_wr, m_err_wr, m_empty, m_prog_rd, m_err_rd;

  function automatic logic [W-1:0] gray(input int v);
    logic [W-1:0] b;
    b = v[W-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic drive_idle();
    wr_if.loc_en = 1'b0; wr_if.loc_gry_cnt = gray(w); wr_if.loc_gry_cnt_nxt = gray(w);
    wr_if.rmt_gry_ptr = gray(r); wr_if.thr = thr_wr;
    rd_if.loc_en = 1'b0; rd_if.loc_gry_cnt = gray(r); rd_if.loc_gry_cnt_nxt = gray(r);
    rd_if.rmt_gry_ptr = gray(w); rd_if.thr = thr_rd;
  endtask

  task automatic model_reset();
    w = 0; r = 0;
    wr_hist.delete(); rd_hist.delete();
    for (int i = 0; i < S; i++) begin wr_hist.push_back(0); rd_hist.push_back(0); end
    m_occ_wr = '0; m_occ_rd = '0; m_sync_wr = '0; m_sync_rd = '0;
    m_full = 1'b0; m_prog_wr = 1'b0; m_err_wr = 1'b0;
    m_empty = 1'b1; m_prog_rd = 1'b1; m_err_rd = 1'b0;
    drive_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: drive enables, advance the model, clock, update the counters.
  task automatic step(input logic we, input logic re);
    int seen_w, seen_r;
    wr_if.loc_en = we; wr_if.loc_gry_cnt_nxt = gray(w + int'(we)); wr_if.thr = thr_wr;
    rd_if.loc_en = re; rd_if.loc_gry_cnt_nxt = gray(r + int'(re)); rd_if.thr = thr_rd;
    seen_r = rd_hist.pop_front(); rd_hist.push_back(r);
    seen_w = wr_hist.pop_front(); wr_hist.push_back(w);
    if (we && m_full)  m_err_wr = 1'b1;
    if (re && m_empty) m_err_rd = 1'b1;
    w = w + int'(we);
    r = r + int'(re);
    m_occ_wr  = W'(w - seen_r);
    m_full    = (int'(m_occ_wr) == DEPTH);
    m_prog_wr = (m_occ_wr >= thr_wr);
    m_occ_rd  = W'(seen_w - r);
    m_empty   = (m_occ_rd == '0);
    m_prog_rd = (m_occ_rd <= thr_rd);
    m_sync_wr = gray(rd_hist[0]);
    m_sync_rd = gray(wr_hist[0]);
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (wr_if.ptr_flag !== 1'b0) begin n_fail++; $display("FAIL rst_wr_flag: got %0d expected 0", wr_if.ptr_flag); end
    n_checks++; if (wr_if.prog_flag !== 1'b0) begin n_fail++; $display("FAIL rst_wr_prog: got %0d expected 0", wr_if.prog_flag); end
    n_checks++; if (wr_if.occ !== 5'd0) begin n_fail++; $display("FAIL rst_wr_occ: got %0d expected 0", wr_if.occ); end
    n_checks++; if (wr_if.ptr_err !== 1'b0) begin n_fail++; $display("FAIL rst_wr_err: got %0d expected 0", wr_if.ptr_err); end
    n_checks++; if (wr_if.rmt_gry_sync !== 5'd0) begin n_fail++; $display("FAIL rst_wr_sync: got %0d expected 0", wr_if.rmt_gry_sync); end
    n_checks++; if (rd_if.ptr_flag !== 1'b1) begin n_fail++; $display("FAIL rst_rd_flag: got %0d expected 1", rd_if.ptr_flag); end
    n_checks++; if (rd_if.prog_flag !== 1'b1) begin n_fail++; $display("FAIL rst_rd_prog: got %0d expected 1", rd_if.prog_flag); end
    n_checks++; if (rd_if.occ !== 5'd0) begin n_fail++; $display("FAIL rst_rd_occ: got %0d expected 0", rd_if.occ); end
    n_checks++; if (rd_if.ptr_err !== 1'b0) begin n_fail++; $display("FAIL rst_rd_err: got %0d expected 0", rd_if.ptr_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_wr_fill();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0);
      n_checks++; if (int'(wr_if.occ) !== i) begin n_fail++; $display("FAIL fill_occ: got %0d expected %0d", wr_if.occ, i); end
      n_checks++; if (wr_if.ptr_flag !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_full: got %0d expected %0d at occ %0d", wr_if.ptr_flag, (i == DEPTH), i); end
      n_checks++; if (wr_if.prog_flag !== (i >= 12)) begin n_fail++; $display("FAIL fill_prog: got %0d expected %0d at occ %0d", wr_if.prog_flag, (i >= 12), i); end
      n_checks++; if (rd_if.occ !== m_occ_rd) begin n_fail++; $display("FAIL fill_rd_occ: got %0d expected %0d", rd_if.occ, m_occ_rd); end
      n_checks++; if (rd_if.ptr_flag !== m_empty) begin n_fail++; $display("FAIL fill_rd_empty: got %0d expected %0d", rd_if.ptr_flag, m_empty); end
    end
    repeat (3) step(1'b0, 1'b0);
    n_checks++; if (rd_if.occ !== 5'd16) begin n_fail++; $display("FAIL fill_rd_occ_final: got %0d expected 16", rd_if.occ); end
    n_checks++; if (rd_if.ptr_flag !== 1'b0) begin n_fail++; $display("FAIL fill_rd_empty_final: got %0d expected 0", rd_if.ptr_flag); end
    n_checks++; if (rd_if.prog_flag !== 1'b0) begin n_fail++; $display("FAIL fill_rd_prog_final: got %0d expected 0", rd_if.prog_flag); end
  endtask

  task automatic test_remote_drain();
    step(1'b0, 1'b1);
    n_checks++; if (rd_if.occ !== 5'd15) begin n_fail++; $display("FAIL drain_rd_occ: got %0d expected 15", rd_if.occ); end
    n_checks++; if (wr_if.ptr_flag !== 1'b1) begin n_fail++; $display("FAIL drain_full_e0: got %0d expected 1", wr_if.ptr_flag); end
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0);
      n_checks++; if (wr_if.ptr_flag !== (i < 3)) begin n_fail++; $display("FAIL drain_full_e%0d: got %0d expected %0d", i, wr_if.ptr_flag, (i < 3)); end
      n_checks++; if (int'(wr_if.occ) !== ((i < 3) ? 16 : 15)) begin n_fail++; $display("FAIL drain_occ_e%0d: got %0d expected %0d", i, wr_if.occ, ((i < 3) ? 16 : 15)); end
      n_checks++; if (wr_if.rmt_gry_sync !== ((i >= 2) ? 5'd1 : 5'd0)) begin n_fail++; $display("FAIL drain_sync_e%0d: got %0d expected %0d", i, wr_if.rmt_gry_sync, (i >= 2)); end
    end
  endtask

  task automatic test_misuse();
    do_reset();
    repeat (DEPTH) step(1'b1, 1'b0);
    n_checks++; if (wr_if.ptr_err !== 1'b0) begin n_fail++; $display("FAIL misuse_err_before: got %0d expected 0", wr_if.ptr_err); end
    step(1'b1, 1'b0);
    n_checks++; if (wr_if.ptr_err !== 1'b1) begin n_fail++; $display("FAIL misuse_err_set: got %0d expected 1", wr_if.ptr_err); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      n_checks++; if (wr_if.ptr_err !== 1'b1) begin n_fail++; $display("FAIL misuse_err_sticky: got %0d expected 1", wr_if.ptr_err); end
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (wr_if.ptr_err !== 1'b0) begin n_fail++; $display("FAIL misuse_err_clear: got %0d expected 0", wr_if.ptr_err); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (9) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    n_checks++; if (wr_if.occ !== 5'd9) begin n_fail++; $display("FAIL mid_wr_occ: got %0d expected 9", wr_if.occ); end
    n_checks++; if (rd_if.occ !== 5'd9) begin n_fail++; $display("FAIL mid_rd_occ: got %0d expected 9", rd_if.occ); end
    n_checks++; if (rd_if.rmt_gry_sync !== gray(9)) begin n_fail++; $display("FAIL mid_rd_sync: got %0d expected %0d", rd_if.rmt_gry_sync, gray(9)); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (wr_if.occ !== 5'd0) begin n_fail++; $display("FAIL mid_rst_wr_occ: got %0d expected 0", wr_if.occ); end
    n_checks++; if (wr_if.ptr_flag !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_flag: got %0d expected 0", wr_if.ptr_flag); end
    n_checks++; if (wr_if.prog_flag !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_prog: got %0d expected 0", wr_if.prog_flag); end
    n_checks++; if (rd_if.occ !== 5'd0) begin n_fail++; $display("FAIL mid_rst_rd_occ: got %0d expected 0", rd_if.occ); end
    n_checks++; if (rd_if.ptr_flag !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rd_flag: got %0d expected 1", rd_if.ptr_flag); end
    n_checks++; if (rd_if.prog_flag !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rd_prog: got %0d expected 1", rd_if.prog_flag); end
    n_checks++; if (rd_if.rmt_gry_sync !== 5'd0) begin n_fail++; $display("FAIL mid_rst_rd_sync: got %0d expected 0", rd_if.rmt_gry_sync); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    int   wd, rdn, cyc, wdiv, rdiv;
    logic we, re;
    do_reset();
    thr_rd = W'($urandom_range(0, DEPTH));
    wd = 0; rdn = 0; cyc = 0; wdiv = 1; rdiv = 1;
    while ((wd < 40 || rdn < 40) && cyc < 3000) begin
      if (cyc % 16 == 0) begin
        wdiv = $urandom_range(1, 4);
        rdiv = $urandom_range(1, 4);
      end
      we = (wd < 40) && !m_full && ($urandom_range(1, wdiv) == 1);
      re = (rdn < 40) && !m_empty && ($urandom_range(1, rdiv) == 1);
      step(we, re);
      wd  += int'(we);
      rdn += int'(re);
      cyc++;
      n_checks++; if (wr_if.occ !== m_occ_wr) begin n_fail++; $display("FAIL wrap_wr_occ: got %0d expected %0d", wr_if.occ, m_occ_wr); end
      n_checks++; if (wr_if.ptr_flag !== m_full) begin n_fail++; $display("FAIL wrap_wr_full: got %0d expected %0d", wr_if.ptr_flag, m_full); end
      n_checks++; if (wr_if.prog_flag !== m_prog_wr) begin n_fail++; $display("FAIL wrap_wr_prog: got %0d expected %0d", wr_if.prog_flag, m_prog_wr); end
      n_checks++; if (wr_if.rmt_gry_sync !== m_sync_wr) begin n_fail++; $display("FAIL wrap_wr_sync: got %0d expected %0d", wr_if.rmt_gry_sync, m_sync_wr); end
      n_checks++; if (wr_if.ptr_err !== m_err_wr) begin n_fail++; $display("FAIL wrap_wr_err: got %0d expected %0d", wr_if.ptr_err, m_err_wr); end
      n_checks++; if (rd_if.occ !== m_occ_rd) begin n_fail++; $display("FAIL wrap_rd_occ: got %0d expected %0d", rd_if.occ, m_occ_rd); end
      n_checks++; if (rd_if.ptr_flag !== m_empty) begin n_fail++; $display("FAIL wrap_rd_empty: got %0d expected %0d", rd_if.ptr_flag, m_empty); end
      n_checks++; if (rd_if.prog_flag !== m_prog_rd) begin n_fail++; $display("FAIL wrap_rd_prog: got %0d expected %0d", rd_if.prog_flag, m_prog_rd); end
      n_checks++; if (rd_if.rmt_gry_sync !== m_sync_rd) begin n_fail++; $display("FAIL wrap_rd_sync: got %0d expected %0d", rd_if.rmt_gry_sync, m_sync_rd); end
      n_checks++; if (rd_if.ptr_err !== m_err_rd) begin n_fail++; $display("FAIL wrap_rd_err: got %0d expected %0d", rd_if.ptr_err, m_err_rd); end
      n_checks++; if (int'(rd_if.occ) > DEPTH) begin n_fail++; $display("FAIL wrap_rd_occ_max: got %0d expected <= %0d", rd_if.occ, DEPTH); end
      n_checks++; if (rd_if.ptr_flag === 1'b0 && rd_if.occ === 5'd0) begin n_fail++; $display("FAIL wrap_empty_low_at_zero: got empty 0 expected 1 at occ 0"); end
    end
    n_checks++; if (wd != 40 || rdn != 40) begin n_fail++; $display("FAIL wrap_budget: got %0d writes %0d reads expected 40/40", wd, rdn); end
    repeat (4) step(1'b0, 1'b0);
    n_checks++; if (rd_if.ptr_flag !== 1'b1) begin n_fail++; $display("FAIL wrap_final_empty: got %0d expected 1", rd_if.ptr_flag); end
    n_checks++; if (rd_if.occ !== 5'd0) begin n_fail++; $display("FAIL wrap_final_rd_occ: got %0d expected 0", rd_if.occ); end
    n_checks++; if (wr_if.occ !== 5'd0) begin n_fail++; $display("FAIL wrap_final_wr_occ: got %0d expected 0", wr_if.occ); end
    n_checks++; if (wr_if.ptr_flag !== 1'b0) begin n_fail++; $display("FAIL wrap_final_full: got %0d expected 0", wr_if.ptr_flag); end
  endtask

  // Hard time limit in case anything stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    thr_wr   = 5'd12;
    thr_rd   = 5'd4;
    rst_n    = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    test_reset();
    test_wr_fill();
    test_remote_drain();
    test_misuse();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gry_ptr_sync.md
# gry_ptr_sync

Clock-domain-crossing pointer comparator for the async FIFO. It takes the local gray pointer from the local gray counter, both the current value and the next value. It synchronizes the gray pointer from the opposite clock domain and produces registered status for the local side: a full or empty flag, occupancy, a programmable-threshold flag and a sticky misuse error. One instance sits on the write side (LOCAL_IS_WR=1) and one on the read side (LOCAL_IS_WR=0).

## Interface
- PTR_W, 5: pointer width, equal to FIFO address width + 1. The MSB is the wrap bit. Minimum 2.
- SYNC_STAGES, 2: depth of the flop chain on the remote pointer. Minimum 2.
- LOCAL_IS_WR, 1: 1 means local side writes (flag means full). 0 means local side reads (flag means empty).

- clk  in  1  local domain clock
- rst_n  in  1  reset, asynchronous, active-low
- loc_gry_cnt  in  PTR_W  local gray pointer, registered
- loc_gry_cnt_nxt  in  PTR_W  local gray pointer value for the next cycle
- loc_en  in  1  local push (WR) or pop (RD) request; this is the same signal that increments the local counter
- rmt_gry_ptr  in  PTR_W  gray pointer from the remote domain; asynchronous to clk
- thr  in  PTR_W  occupancy threshold, quasi-static
- rmt_gry_sync  out  PTR_W  last stage of the synchronizer chain
- ptr_flag  out  1  full (WR) or empty (RD)
- prog_flag  out  1  almost-full (WR) or almost-empty (RD)
- occ  out  PTR_W  FIFO occupancy, range 0..2^(PTR_W-1)
- ptr_err  out  1  sticky error: overflow (WR) or underflow (RD)

## Operation
- Synchronizer: rmt_gry_ptr passes through SYNC_STAGES flops. Every stage resets to 0. No logic is placed between stages.
- Gray-to-binary: rmt_bin[i] = ^rmt_gry_sync[PTR_W-1:i]. The same conversion is applied to loc_gry_cnt_nxt to give loc_bin_nxt. Both are combinational.
- Flag, WR mode: full_c = (loc_gry_cnt_nxt == {~rmt_gry_sync[PTR_W-1:PTR_W-2], rmt_gry_sync[PTR_W-3:0]}). When PTR_W=2, compare against ~rmt_gry_sync.
- Flag, RD mode: empty_c = (loc_gry_cnt_nxt == rmt_gry_sync).
- Occupancy:
  - WR mode: occ_c = loc_bin_nxt - rmt_bin.
  - RD mode: occ_c = rmt_bin - loc_bin_nxt.
  - Subtraction is modulo 2^PTR_W.
  - With legal use the result never exceeds 2^(PTR_W-1).
- Programmable flag:
  - WR mode: prog_c = (occ_c >= thr).
  - RD mode: prog_c = (occ_c <= thr).
  - Comparison is unsigned.
- Registers: ptr_flag, prog_flag and occ are registered from full_c/empty_c, prog_c and occ_c on every clk edge. No enable.
- Error:
  - ptr_err sets when loc_en=1 and ptr_flag=1 in the same cycle.
  - Once set it stays high until rst_n is asserted.
  - The block never gates loc_en. Gating is the user's job.
- Flags are conservative. The local side sees its own updates immediately and remote updates late.
  - In WR mode, full may stay high after a remote read.
  - In RD mode, empty may stay high after a remote write.
  - Neither flag ever deasserts falsely.

## Timing
- Values during reset:
  - sync chain, rmt_gry_sync = 0
  - ptr_flag = 0 (WR) or 1 (RD)
  - prog_flag = 0 (WR) or 1 (RD)
  - occ = 0
  - ptr_err = 0
- The block pairs with counters whose rst_val is 0 on both sides.
- Local update: flag, prog_flag and occ reflect a local increment on the same edge at which loc_gry_cnt takes loc_gry_cnt_nxt. Latency is 0 relative to the counter.
- Remote update: a change on rmt_gry_ptr appears on rmt_gry_sync after SYNC_STAGES edges. It reaches ptr_flag, prog_flag and occ one edge later, SYNC_STAGES+1 edges in total.
- Simultaneous local and remote updates are both folded into the same registered result. No special priority applies.
- Wrap-around: the pointer rolls from 2^PTR_W-1 to 0 with a single gray bit change. Occupancy stays correct through the roll because the subtraction is modular.
- Reset mid-operation: all outputs return to their reset values asynchronously. Normal operation resumes on the first edge after rst_n deasserts.

## Test plan
- Reset, WR mode, PTR_W=5, rmt_gry_ptr=0 -> ptr_flag=0, occ=0, prog_flag=0, ptr_err=0. RD mode -> ptr_flag=1, prog_flag=1.
- WR fill: 16 consecutive loc_en pulses with remote held at 0 -> occ counts 1..16. ptr_flag rises on the same edge as the 16th increment. With thr=12, prog_flag rises when occ reaches 12.
- Remote drain, WR mode: rmt_gry_ptr steps to gray(1) -> ptr_flag falls exactly 3 edges later (SYNC_STAGES=2) and occ shows 15.
- Wrap-around, RD mode: 40 writes and 40 reads interleaved with random clock ratios -> occ never exceeds 16, empty is never low while occ=0, and the final state is empty=1, occ=0.
- Misuse: in WR mode, loc_en=1 while full -> ptr_err rises on the next edge and stays 1 after loc_en drops. It clears only on rst_n.
- Reset mid-operation: assert rst_n low at occ=9 -> all outputs go to their reset values immediately, without waiting for a clock edge.
